data_mem_slave: RTL and testbench

Memory-side responder for the core's load/store path: accepts one word-aligned request per transaction, either a read or a lane-masked write. Consumes the pre-aligned write word and 4-bit byte mask produced by the store path. Returns the raw 32-bit word that the load path extracts bytes and half-words from. Sits between the core's memory stage and a synthesizable byte-lane RAM, with programmable wait states so pipeline stall logic can be exercised.

---
 rtl/data_mem_slave_pkg.sv | 31 +++
 rtl/dmem_byte_ram.sv | 36 +++
 rtl/data_mem_slave.sv | 122 ++++++++++++
 tb/tb_data_mem_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_slave_pkg.sv
// Shared definitions for the data memory slave: FSM encoding, mask
// constants, lane geometry and the address-window check.
package data_mem_slave_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LANES      = 4;
    localparam int LANE_WIDTH = 8;

    // Transaction FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // Byte-lane mask encodings used by the store path
    localparam logic [3:0] MASK_READ = 4'b0000;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // True when addr lies in [base, base + 4*2**aw). The subtraction is done
    // in 33 bits so addresses below base show up as a borrow instead of
    // wrapping into the window.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          aw);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return !off[32] && ((off[31:0] >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-lane RAM: four 8-bit arrays sharing one word address, each with its
// own write enable, and a registered read port that returns the word as it
// was before any write on the same edge.
module dmem_byte_ram
    import data_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [LANES-1:0]      we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];
        logic [LANE_WIDTH-1:0] rd_q;

        // Per-lane write and registered read, both gated by the access enable
        always_ff @(posedge clk) begin
            if (en) begin
                if (we[i]) begin
                    mem[addr] <= wdata[LANE_WIDTH*i +: LANE_WIDTH];
                end
                rd_q <= mem[addr];
            end
        end

        assign rdata[LANE_WIDTH*i +: LANE_WIDTH] = rd_q;
    end

endmodule

// File: rtl/data_mem_slave.sv
// Data memory slave for the core's load/store path. One request at a time:
// accept, optional wait states, one RAM access cycle, one response cycle.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so request inputs
// are don't-care while a transaction is in flight. The response is a single
// cycle rsp_valid pulse with no back-pressure; rsp_rdata/rsp_error are held
// until the next response.
module data_mem_slave
    import data_mem_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  accept;
    logic [31:0]           byte_off;
    logic                  unused_off;

    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_mask;
    logic                  lat_err;

    logic                  ram_en;
    logic [LANES-1:0]      ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // Word index relative to the window base; only meaningful when in range
    assign byte_off   = req_addr - BASE_ADDR;
    assign unused_off = ^{byte_off[31:ADDR_WIDTH+2], byte_off[1:0]};

    // Transaction sequencing: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS_INIT;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: state <= ST_RESP;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Capture the request and its range check on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx   <= byte_off[ADDR_WIDTH+1:2];
            lat_wdata <= req_wdata;
            lat_mask  <= req_mask;
            lat_err   <= !addr_in_window(req_addr, BASE_ADDR, ADDR_WIDTH);
        end
    end

    // Out-of-range requests never touch the array
    assign ram_en = (state == ST_ACCESS);
    assign ram_we = ram_en ? (lat_mask & {LANES{!lat_err}}) : '0;

    dmem_byte_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (lat_idx),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // Register the response at the end of RESP; data holds until the next one
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= (state == ST_RESP);
            if (state == ST_RESP) begin
                rsp_error <= lat_err;
                rsp_rdata <= (lat_err || (lat_mask != MASK_READ)) ? 32'd0 : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave: vector table on a WAIT_STATES=1
// instance, back-to-back streaming, latency on WAIT_STATES=0/3 instances,
// and reset during an in-flight write.
module tb_data_mem_slave;
    import data_mem_slave_pkg::*;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0001_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (WAIT_STATES = 1) ----------------
    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_mask  = 4'd0;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;

    data_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    // ---------------- latency DUTs (WAIT_STATES = 0 and 3) ----------------
    logic        b_valid = 1'b0;
    logic [31:0] b_addr  = 32'd0;
    logic [31:0] b_wdata = 32'd0;
    logic [3:0]  b_mask  = 4'd0;
    logic        b_ready0, b_rvalid0, b_err0;
    logic        b_ready3, b_rvalid3, b_err3;
    logic [31:0] b_rdata0, b_rdata3;

    data_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .resetn(resetn),
        .req_valid(b_valid), .req_ready(b_ready0),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_mask(b_mask),
        .rsp_valid(b_rvalid0), .rsp_rdata(b_rdata0), .rsp_error(b_err0)
    );

    data_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .resetn(resetn),
        .req_valid(b_valid), .req_ready(b_ready3),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_mask(b_mask),
        .rsp_valid(b_rvalid3), .rsp_rdata(b_rdata3), .rsp_error(b_err3)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One transaction on the main DUT, entered and left at a negedge.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic vld_after, output logic [31:0] rd_after);
        int guard;
        req_addr  = a;
        req_wdata = w;
        req_mask  = m;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check32("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        @(posedge clk);
        #1;
        vld_after = rsp_valid;
        rd_after  = rsp_rdata;
        @(negedge clk);
    endtask

    // One transaction on both latency DUTs; reports edges from accept to pulse.
    task automatic b_txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] m,
                         output int l0, output int l3,
                         output logic [31:0] r0, output logic [31:0] r3,
                         output logic e0, output logic e3);
        int guard;
        b_addr  = a;
        b_wdata = w;
        b_mask  = m;
        b_valid = 1'b1;
        guard = 0;
        while (!(b_ready0 && b_ready3) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        l0 = -1; l3 = -1;
        r0 = 32'hFFFF_FFFF; r3 = 32'hFFFF_FFFF;
        e0 = 1'b1; e3 = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (b_rvalid0 && l0 < 0) begin l0 = e; r0 = b_rdata0; e0 = b_err0; end
            if (b_rvalid3 && l3 < 0) begin l3 = e; r3 = b_rdata3; e3 = b_err3; end
        end
        @(negedge clk);
    endtask

    // Start a write on the main DUT and make reset be sampled low at the
    // n-th edge after the accept edge; then watch for a stray response.
    task automatic reset_mid(input logic [31:0] a, input logic [31:0] w, input int n);
        int guard;
        int stray;
        req_addr  = a;
        req_wdata = w;
        req_mask  = MASK_WORD;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check32($sformatf("rst%0d_ready", n), {31'd0, req_ready}, 32'd1);
        check32($sformatf("rst%0d_rsp_valid", n), {31'd0, rsp_valid}, 32'd0);
        check32($sformatf("rst%0d_rsp_rdata", n), rsp_rdata, 32'd0);
        check32($sformatf("rst%0d_rsp_error", n), {31'd0, rsp_error}, 32'd0);
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid) stray++;
        end
        check32($sformatf("rst%0d_no_response", n), stray, 32'd0);
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    vec_t vecs [18];
    vec_t strm [7];

    initial begin
        logic [31:0] rd, rd_after, r0, r3;
        logic        er, vld_after, e0, e3;
        int          lat, l0, l3;
        int          idx, nrsp, nacc, cyc, extra;
        logic        acc;
        logic [31:0] exp_v;

        vecs[0]  = '{32'h0001_0004, 32'hDEAD_BEEF, MASK_WORD, 32'h0000_0000, 1'b0};
        vecs[1]  = '{32'h0001_0004, 32'h0000_0000, MASK_READ, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h0001_0004, 32'h0055_0000, 4'b0100,   32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h0001_0004, 32'h0000_0000, MASK_READ, 32'hDE55_BEEF, 1'b0};
        vecs[4]  = '{32'h0000_FFFC, 32'h0000_0000, MASK_READ, 32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h0001_1000, 32'h0000_0000, MASK_READ, 32'h0000_0000, 1'b1};
        vecs[6]  = '{32'h0001_0000, 32'h1122_3344, MASK_WORD, 32'h0000_0000, 1'b0};
        vecs[7]  = '{32'h0001_1000, 32'hFFFF_FFFF, MASK_WORD, 32'h0000_0000, 1'b1};
        vecs[8]  = '{32'h0001_0000, 32'h0000_0000, MASK_READ, 32'h1122_3344, 1'b0};
        vecs[9]  = '{32'h0001_0FFC, 32'hA5A5_5A5A, MASK_WORD, 32'h0000_0000, 1'b0};
        vecs[10] = '{32'h0001_0FFE, 32'h0000_00CC, 4'b0001,   32'h0000_0000, 1'b0};
        vecs[11] = '{32'h0000_FFFC, 32'hFFFF_FFFF, MASK_WORD, 32'h0000_0000, 1'b1};
        vecs[12] = '{32'h0001_0FFD, 32'h0000_0000, MASK_READ, 32'hA5A5_5ACC, 1'b0};
        vecs[13] = '{32'h0001_0008, 32'hFFFF_FFFF, MASK_WORD, 32'h0000_0000, 1'b0};
        vecs[14] = '{32'h0001_0008, 32'h1200_0034, 4'b1001,   32'h0000_0000, 1'b0};
        vecs[15] = '{32'h0001_0008, 32'h0000_0000, MASK_READ, 32'h12FF_FF34, 1'b0};
        vecs[16] = '{32'h0001_0004, 32'h0000_0000, MASK_READ, 32'hDE55_BEEF, 1'b0};
        vecs[17] = '{32'h0001_0000, 32'h0000_0000, MASK_READ, 32'h1122_3344, 1'b0};

        strm[0] = '{32'h0001_0010, 32'h0000_0001, MASK_WORD, 32'h0000_0000, 1'b0};
        strm[1] = '{32'h0001_0010, 32'h0000_0000, MASK_READ, 32'h0000_0001, 1'b0};
        strm[2] = '{32'h0001_0014, 32'hAABB_CCDD, MASK_WORD, 32'h0000_0000, 1'b0};
        strm[3] = '{32'h0001_0010, 32'h0000_0000, MASK_READ, 32'h0000_0001, 1'b0};
        strm[4] = '{32'h0001_0014, 32'h0000_0000, MASK_READ, 32'hAABB_CCDD, 1'b0};
        strm[5] = '{32'h0001_0010, 32'h0000_FF00, 4'b0010,   32'h0000_0000, 1'b0};
        strm[6] = '{32'h0001_0010, 32'h0000_0000, MASK_READ, 32'h0000_FF01, 1'b0};

        // Reset
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check32("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("reset_rsp_rdata", rsp_rdata, 32'd0);
        check32("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        check32("reset_ready_ws0", {31'd0, b_ready0}, 32'd1);
        check32("reset_ready_ws3", {31'd0, b_ready3}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Vector table, WAIT_STATES = 1 -> 3 edges from accept to pulse
        for (int i = 0; i < 18; i++) begin
            do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, er, lat, vld_after, rd_after);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_error", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check32($sformatf("vec%0d_latency", i), lat, 32'd3);
            check32($sformatf("vec%0d_pulse_one_cycle", i), {31'd0, vld_after}, 32'd0);
            check32($sformatf("vec%0d_rdata_hold", i), rd_after, vecs[i].exp_rdata);
        end

        // Streaming: req_valid stays high, next request presented while busy
        idx = 0; nrsp = 0; nacc = 0; cyc = 0;
        req_addr  = strm[0].addr;
        req_wdata = strm[0].wdata;
        req_mask  = strm[0].mask;
        req_valid = 1'b1;
        while (nrsp < 7 && cyc < 200) begin
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                exp_q.push_back(strm[idx].exp_rdata);
                nacc++;
                check32($sformatf("strm%0d_ready_low", idx), {31'd0, req_ready}, 32'd0);
                idx++;
                if (idx < 7) begin
                    req_addr  = strm[idx].addr;
                    req_wdata = strm[idx].wdata;
                    req_mask  = strm[idx].mask;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check32("strm_spurious_response", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check32($sformatf("strm_rsp%0d_rdata", nrsp), rsp_rdata, exp_v);
                end
                nrsp++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check32("strm_accepts", nacc, 32'd7);
        check32("strm_responses", nrsp, 32'd7);
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (rsp_valid) extra++;
        end
        check32("strm_no_extra_response", extra, 32'd0);
        @(negedge clk);

        // Latency with WAIT_STATES = 0 and 3
        b_txn(32'h0001_0020, 32'hCAFE_F00D, MASK_WORD, l0, l3, r0, r3, e0, e3);
        check32("ws0_write_latency", l0, 32'd2);
        check32("ws3_write_latency", l3, 32'd5);
        check32("ws0_write_rdata", r0, 32'd0);
        check32("ws3_write_rdata", r3, 32'd0);
        b_txn(32'h0001_0020, 32'h0000_0000, MASK_READ, l0, l3, r0, r3, e0, e3);
        check32("ws0_read_latency", l0, 32'd2);
        check32("ws3_read_latency", l3, 32'd5);
        check32("ws0_read_rdata", r0, 32'hCAFE_F00D);
        check32("ws3_read_rdata", r3, 32'hCAFE_F00D);
        check32("ws0_read_error", {31'd0, e0}, 32'd0);
        check32("ws3_read_error", {31'd0, e3}, 32'd0);

        // Reset during WAIT of a write: dropped, old word survives
        reset_mid(32'h0001_0004, 32'h1234_5678, 1);
        do_txn(32'h0001_0004, 32'h0, MASK_READ, rd, er, lat, vld_after, rd_after);
        check32("rst_wait_old_word", rd, 32'hDE55_BEEF);
        check32("rst_wait_read_latency", lat, 32'd3);

        // Reset during RESP of a write: access already happened, so it sticks
        reset_mid(32'h0001_0008, 32'h0BAD_F00D, 3);
        do_txn(32'h0001_0008, 32'h0, MASK_READ, rd, er, lat, vld_after, rd_after);
        check32("rst_resp_committed_word", rd, 32'h0BAD_F00D);
        check32("rst_resp_read_error", {31'd0, er}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something stalls outside the bounded waits
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
